// File: rtl/data_mem_stage.sv
// Data-memory stage: one 64-bit load or store per request against a word array with fixed LATENCY.
// Optional build macro DMEM_ALIGN_CHECK_EN flags (and suppresses) accesses with Address[2:0] != 0.
module data_mem_stage #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [63:0] Address,
  input  logic [63:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [63:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        AlignErr
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = DEPTH_LOG2 + 3;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [63:0]         data_q;
  logic                wr_q;
  logic [63:0]         mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx_c;
  logic                  misalign_c;
  logic                  accept_c;
  logic                  finish_c;
  logic                  unused_addr_c;

  // Bits above the array index are intentionally dropped, so addresses wrap.
  assign unused_addr_c = ^Address[63:ADDR_W];
  assign idx_c         = addr_q[ADDR_W-1:3];
  assign accept_c      = ((state == IDLE) || (state == DONE)) && (MemRead || MemWrite);
  assign finish_c      = (state == WAIT) && (cnt == '0);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_c = |addr_q[2:0];
`else
  logic unused_low_c;
  assign unused_low_c = ^addr_q[2:0];
  assign misalign_c   = 1'b0;
`endif

  // Control FSM with registered Busy/Done/AlignErr/ReadData.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      AlignErr <= 1'b0;
      ReadData <= 64'h0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
    end else begin
      Done     <= 1'b0;
      AlignErr <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept_c) begin
            state  <= WAIT;
            Busy   <= 1'b1;
            cnt    <= CNT_W'(LATENCY - 1);
            addr_q <= Address[ADDR_W-1:0];
            data_q <= WriteData;
            wr_q   <= MemWrite;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (finish_c) begin
            state    <= DONE;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            AlignErr <= misalign_c;
            if (!wr_q && !misalign_c) ReadData <= mem[idx_c];
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Store commit; the array itself is never reset.
  always_ff @(posedge Clk) begin
    if (!Reset && finish_c && wr_q && !misalign_c) mem[idx_c] <= data_q;
  end

endmodule
